// File: rtl/isp_pkg.sv
// Shared constants, beat record and FSM encoding for the ISP DRAM picture reader.
// No logic of its own; address helper is purely combinational.
// No flow control here; users apply their own valid/ready handling.
package isp_pkg;

  // Picture layout in DRAM
  localparam logic [31:0] BASE_ADDR  = 32'h0001_0000;
  localparam int unsigned PIC_BYTES  = 3072;
  localparam int unsigned BEATS      = 192;
  localparam int unsigned FIFO_DEPTH = 4;

  // AXI4 encodings
  localparam logic [2:0] AXI_SIZE_16B   = 3'b100;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
  localparam logic [3:0] AXI_ID         = 4'h0;

  // Reader FSM states
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_AR    = 2'd1;
  localparam logic [1:0] ST_RD    = 2'd2;
  localparam logic [1:0] ST_DRAIN = 2'd3;

  // One buffered read beat: 128 data + 8 index + 1 last = 137 bits
  typedef struct packed {
    logic [127:0] data;
    logic [7:0]   idx;
    logic         last;
  } beat_t;

  // Burst start address of a picture; 15*3072 fits easily in 32 bits
  function automatic logic [31:0] pic_addr(input logic [3:0] pic_no);
    return BASE_ADDR + (32'(pic_no) * 32'(PIC_BYTES));
  endfunction

endpackage

// File: rtl/isp_beat_fifo.sv
// Generic synchronous FIFO with occupancy count; head shows zero while empty.
// Latency: a pushed entry is visible at the head the cycle after the push.
// Backpressure: push ignored when full unless a pop happens in the same cycle.
module isp_beat_fifo #(
  parameter int WIDTH = 137,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = empty ? '0 : mem[rd_ptr];

  // Pointer and occupancy bookkeeping; simultaneous push/pop leaves count unchanged
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: the head is masked while empty
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/isp_dram_reader.sv
// AXI4 single-burst picture fetcher feeding 128-bit beats to the ISP core.
// Latency: arvalid one cycle after start; each beat reaches dout one cycle after its R handshake.
// Backpressure: rready follows registered FIFO occupancy only; no path from dout_ready.
module isp_dram_reader (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [3:0]   pic_no,
  output logic         busy,
  output logic         done,
  output logic         err,
  output logic [3:0]   arid_s_inf,
  output logic [31:0]  araddr_s_inf,
  output logic [7:0]   arlen_s_inf,
  output logic [2:0]   arsize_s_inf,
  output logic [1:0]   arburst_s_inf,
  output logic         arvalid_s_inf,
  input  logic         arready_s_inf,
  input  logic [3:0]   rid_s_inf,
  input  logic [127:0] rdata_s_inf,
  input  logic [1:0]   rresp_s_inf,
  input  logic         rlast_s_inf,
  input  logic         rvalid_s_inf,
  output logic         rready_s_inf,
  output logic         dout_valid,
  input  logic         dout_ready,
  output logic [127:0] dout_data,
  output logic [7:0]   dout_idx,
  output logic         dout_last
);

  import isp_pkg::*;

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [1:0]    state;
  logic [7:0]    beat_cnt;
  logic          beat_acc;
  logic          beat_is_last;
  logic          beat_err;
  beat_t         push_beat;
  beat_t         head_beat;
  logic [136:0]  fifo_head;
  logic          fifo_empty;
  logic          fifo_full;
  logic [CW-1:0] fifo_count;

  assign arid_s_inf    = AXI_ID;
  assign arsize_s_inf  = AXI_SIZE_16B;
  assign arburst_s_inf = AXI_BURST_INCR;

  assign rready_s_inf = (state == ST_RD) && (fifo_count < CW'(FIFO_DEPTH));
  assign beat_acc     = rvalid_s_inf && rready_s_inf;
  assign beat_is_last = (beat_cnt == 8'(BEATS - 1));

  // Protocol violations are flagged but never alter the beat count
  assign beat_err = (rresp_s_inf != AXI_RESP_OKAY) || (rid_s_inf != AXI_ID) ||
                    (rlast_s_inf != beat_is_last);

  assign push_beat = '{data: rdata_s_inf, idx: beat_cnt, last: beat_is_last};

  isp_beat_fifo #(
    .WIDTH ($bits(beat_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (beat_acc),
    .push_data (push_beat),
    .pop       (dout_valid && dout_ready),
    .head      (fifo_head),
    .empty     (fifo_empty),
    .full      (fifo_full),
    .count     (fifo_count)
  );

  assign head_beat  = fifo_head;
  assign dout_valid = !fifo_empty;
  assign dout_data  = head_beat.data;
  assign dout_idx   = head_beat.idx;
  assign dout_last  = head_beat.last;

  // Fetch sequencing: address phase, counted data phase, then drain before done
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      busy          <= 1'b0;
      done          <= 1'b0;
      err           <= 1'b0;
      arvalid_s_inf <= 1'b0;
      araddr_s_inf  <= '0;
      arlen_s_inf   <= '0;
      beat_cnt      <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            busy          <= 1'b1;
            err           <= 1'b0;
            araddr_s_inf  <= pic_addr(pic_no);
            arlen_s_inf   <= 8'(BEATS - 1);
            arvalid_s_inf <= 1'b1;
            state         <= ST_AR;
          end
        end
        ST_AR: begin
          if (arready_s_inf) begin
            arvalid_s_inf <= 1'b0;
            beat_cnt      <= '0;
            state         <= ST_RD;
          end
        end
        ST_RD: begin
          if (beat_acc) begin
            if (beat_err) err <= 1'b1;
            beat_cnt <= beat_cnt + 8'd1;
            if (beat_is_last) state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (fifo_empty) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_isp_dram_reader.sv
// Self-checking bench: randomized DRAM slave and core sink around isp_dram_reader.
// Expected data derived from the picture address formula and a fixed DRAM content function.
// Backpressure exercised via random rvalid/dout_ready gaps and an explicit core stall.
module tb_isp_dram_reader;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [3:0]   pic_no;
  logic         busy;
  logic         done;
  logic         err;
  logic [3:0]   arid_s_inf;
  logic [31:0]  araddr_s_inf;
  logic [7:0]   arlen_s_inf;
  logic [2:0]   arsize_s_inf;
  logic [1:0]   arburst_s_inf;
  logic         arvalid_s_inf;
  logic         arready_s_inf;
  logic [3:0]   rid_s_inf;
  logic [127:0] rdata_s_inf;
  logic [1:0]   rresp_s_inf;
  logic         rlast_s_inf;
  logic         rvalid_s_inf;
  logic         rready_s_inf;
  logic         dout_valid;
  logic         dout_ready;
  logic [127:0] dout_data;
  logic [7:0]   dout_idx;
  logic         dout_last;

  isp_dram_reader dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .pic_no        (pic_no),
    .busy          (busy),
    .done          (done),
    .err           (err),
    .arid_s_inf    (arid_s_inf),
    .araddr_s_inf  (araddr_s_inf),
    .arlen_s_inf   (arlen_s_inf),
    .arsize_s_inf  (arsize_s_inf),
    .arburst_s_inf (arburst_s_inf),
    .arvalid_s_inf (arvalid_s_inf),
    .arready_s_inf (arready_s_inf),
    .rid_s_inf     (rid_s_inf),
    .rdata_s_inf   (rdata_s_inf),
    .rresp_s_inf   (rresp_s_inf),
    .rlast_s_inf   (rlast_s_inf),
    .rvalid_s_inf  (rvalid_s_inf),
    .rready_s_inf  (rready_s_inf),
    .dout_valid    (dout_valid),
    .dout_ready    (dout_ready),
    .dout_data     (dout_data),
    .dout_idx      (dout_idx),
    .dout_last     (dout_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  logic [31:0] seed;

  // Test knobs, written only by the main sequence
  int ar_wait_cfg    = 0;
  int r_gap          = 0;
  int sink_gap       = 0;
  bit stall          = 0;
  int rresp_err_beat = -1;
  int rlast_err_beat = -1;
  int rid_err_beat   = -1;

  // DRAM model state
  bit          in_burst = 0;
  bit          pres = 0;
  int          beat_no = 0;
  int          beats_total = 0;
  logic [31:0] burst_addr = '0;
  int          ar_cnt = 0;
  int          r_beats = 0;
  int          ar_wait_cnt = 0;
  int          arvalid_cycles = 0;
  bit          araddr_moved = 0;
  bit          arvalid_prev = 0;
  logic [31:0] araddr_prev = '0;

  // Beats received by the core sink
  logic [127:0] q_data[$];
  int           q_idx[$];
  bit           q_last[$];

  function automatic logic [31:0] exp_addr(input int p);
    return 32'h0001_0000 + 32'(p) * 32'd3072;
  endfunction

  function automatic logic [127:0] dram_word(input logic [31:0] a);
    return {a ^ seed, ~a, a * 32'h9E37_79B9, {a[15:0], a[31:16]} ^ 32'h5A5A_A5A5};
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // DRAM slave: decisions at negedge; a handshake is committed when both sides are high now
  always @(negedge clk) begin
    if (!rst_n) begin
      arready_s_inf = 1'b0;
      rvalid_s_inf  = 1'b0;
      rlast_s_inf   = 1'b0;
      rresp_s_inf   = 2'b00;
      rid_s_inf     = 4'h0;
      rdata_s_inf   = '0;
      in_burst      = 0;
      pres          = 0;
      arvalid_prev  = 0;
      ar_wait_cnt   = ar_wait_cfg;
    end else begin
      if (in_burst && !pres) begin
        if ($urandom_range(99) >= r_gap) begin
          rdata_s_inf  = dram_word(burst_addr + 32'(beat_no * 16));
          rresp_s_inf  = (beat_no == rresp_err_beat) ? 2'b10 : 2'b00;
          rid_s_inf    = (beat_no == rid_err_beat) ? 4'h3 : 4'h0;
          rlast_s_inf  = (beat_no == beats_total - 1) || (beat_no == rlast_err_beat);
          rvalid_s_inf = 1'b1;
          pres         = 1;
        end else begin
          rvalid_s_inf = 1'b0;
        end
      end else if (!in_burst) begin
        rvalid_s_inf = 1'b0;
      end
      if (pres && rready_s_inf) begin
        pres = 0;
        beat_no++;
        r_beats++;
        if (beat_no == beats_total) in_burst = 0;
      end
      if (arvalid_s_inf && !arvalid_prev) begin
        arvalid_cycles = 0;
        araddr_moved   = 0;
        araddr_prev    = araddr_s_inf;
      end
      if (arvalid_s_inf) begin
        arvalid_cycles++;
        if (araddr_s_inf !== araddr_prev) araddr_moved = 1;
      end
      if (!arvalid_s_inf) ar_wait_cnt = ar_wait_cfg;
      if (arvalid_s_inf && !in_burst && ar_wait_cnt == 0) begin
        arready_s_inf = 1'b1;
      end else begin
        arready_s_inf = 1'b0;
        if (arvalid_s_inf && ar_wait_cnt > 0) ar_wait_cnt--;
      end
      if (arready_s_inf && arvalid_s_inf) begin
        burst_addr  = araddr_s_inf;
        beats_total = int'(arlen_s_inf) + 1;
        beat_no     = 0;
        in_burst    = 1;
        ar_cnt++;
      end
      arvalid_prev = arvalid_s_inf;
    end
  end

  // Core sink: records every beat that will be taken at the next posedge
  always @(negedge clk) begin
    if (!rst_n) begin
      dout_ready = 1'b0;
    end else begin
      dout_ready = !stall && ($urandom_range(99) >= sink_gap);
      if (dout_valid && dout_ready) begin
        q_data.push_back(dout_data);
        q_idx.push_back(int'(dout_idx));
        q_last.push_back(dout_last);
      end
    end
  end

  int base;

  // Issue start from a negedge; checks the registered AR outputs one cycle later
  task automatic start_fetch(input int p);
    @(negedge clk);
    base   = q_data.size();
    start  = 1'b1;
    pic_no = 4'(p);
    @(negedge clk);
    start  = 1'b0;
    pic_no = 4'($urandom);
    check($sformatf("busy_after_start_p%0d", p), busy, 1'b1);
    check($sformatf("err_cleared_p%0d", p), err, 1'b0);
    check($sformatf("arvalid_rise_p%0d", p), arvalid_s_inf, 1'b1);
    check($sformatf("araddr_p%0d", p), araddr_s_inf, exp_addr(p));
    check($sformatf("arlen_p%0d", p), arlen_s_inf, 8'd191);
  endtask

  task automatic wait_beats(input int n);
    int t = 0;
    while (q_data.size() < base + n && t < 3000) begin
      @(negedge clk);
      t++;
    end
    check($sformatf("wait_beats_%0d", n), q_data.size() >= base + n, 1'b1);
  endtask

  task automatic finish_fetch(input int p, input bit exp_err, output int cyc);
    int bad = 0;
    int n;
    cyc = 1;
    while (!done && cyc < 5000) begin
      @(negedge clk);
      cyc++;
    end
    check($sformatf("done_seen_p%0d", p), done, 1'b1);
    check($sformatf("err_at_done_p%0d", p), err, exp_err);
    check($sformatf("busy_at_done_p%0d", p), busy, 1'b0);
    @(negedge clk);
    check($sformatf("done_one_cycle_p%0d", p), done, 1'b0);
    n = q_data.size() - base;
    check($sformatf("beat_count_p%0d", p), n, 192);
    for (int i = 0; i < n; i++) begin
      if (q_data[base+i] !== dram_word(exp_addr(p) + 32'(i * 16)) ||
          q_idx[base+i] != i || q_last[base+i] != (i == 191))
        bad++;
    end
    check($sformatf("beat_content_p%0d", p), bad, 0);
    check($sformatf("araddr_stable_p%0d", p), araddr_moved, 1'b0);
  endtask

  int cyc;
  int ar_before;
  int q_snap;
  int p;

  initial begin
    seed   = $urandom;
    rst_n  = 1'b0;
    start  = 1'b0;
    pic_no = 4'h0;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_arvalid", arvalid_s_inf, 1'b0);
    check("rst_araddr", araddr_s_inf, 32'h0);
    check("rst_arlen", arlen_s_inf, 8'h0);
    check("rst_rready", rready_s_inf, 1'b0);
    check("rst_dout_valid", dout_valid, 1'b0);
    check("rst_dout_data", dout_data, 128'h0);
    check("rst_dout_idx", dout_idx, 8'h0);
    check("rst_dout_last", dout_last, 1'b0);
    check("const_arid", arid_s_inf, 4'h0);
    check("const_arsize", arsize_s_inf, 3'b100);
    check("const_arburst", arburst_s_inf, 2'b01);
    rst_n = 1'b1;
    @(negedge clk);

    // Picture 0, immediate arready, core never stalls: fixed latency
    start_fetch(0);
    finish_fetch(0, 1'b0, cyc);
    check("latency_p0", cyc, 196);
    check("ar_count_1", ar_cnt, 1);

    // Picture 15 with arready held off 7 cycles
    ar_wait_cfg = 7;
    start_fetch(15);
    check("araddr_p15_literal", araddr_s_inf, 32'h0001_B400);
    finish_fetch(15, 1'b0, cyc);
    check("arvalid_hold_cycles", arvalid_cycles, 8);
    ar_wait_cfg = 0;

    // Core stalls mid-burst: rready must drop once the FIFO fills
    p = $urandom_range(15);
    start_fetch(p);
    wait_beats(50);
    stall = 1;
    @(negedge clk);
    q_snap = q_data.size();
    repeat (10) @(negedge clk);
    check("stall_rready_low", rready_s_inf, 1'b0);
    check("stall_dout_valid", dout_valid, 1'b1);
    check("stall_no_output", q_data.size(), q_snap);
    check("stall_busy", busy, 1'b1);
    stall = 0;
    finish_fetch(p, 1'b0, cyc);

    // Error response on beat 5; err sticky through done
    rresp_err_beat = 5;
    start_fetch(2);
    finish_fetch(2, 1'b1, cyc);
    rresp_err_beat = -1;

    // Early rlast on beat 100, with random gaps
    rlast_err_beat = 100;
    r_gap = 20;
    sink_gap = 20;
    start_fetch(9);
    finish_fetch(9, 1'b1, cyc);
    rlast_err_beat = -1;

    // Wrong rid on one beat
    rid_err_beat = 37;
    start_fetch(4);
    finish_fetch(4, 1'b1, cyc);
    rid_err_beat = -1;
    r_gap = 0;
    sink_gap = 0;

    // start while busy is ignored
    ar_before = ar_cnt;
    start_fetch(7);
    wait_beats(10);
    start  = 1'b1;
    pic_no = 4'd3;
    @(negedge clk);
    start  = 1'b0;
    check("busy_during_ignored_start", busy, 1'b1);
    finish_fetch(7, 1'b0, cyc);
    repeat (5) @(negedge clk);
    check("no_second_ar", ar_cnt, ar_before + 1);
    check("idle_after_ignored_start", busy, 1'b0);

    // Randomized fetches
    for (int k = 0; k < 3; k++) begin
      p           = $urandom_range(15);
      ar_wait_cfg = $urandom_range(3);
      r_gap       = $urandom_range(40);
      sink_gap    = $urandom_range(40);
      start_fetch(p);
      finish_fetch(p, 1'b0, cyc);
    end
    ar_wait_cfg = 0;
    r_gap = 0;
    sink_gap = 0;

    // Reset mid-burst clears everything immediately
    p = $urandom_range(15);
    start_fetch(p);
    wait_beats(20);
    rst_n = 1'b0;
    #1;
    check("midrst_busy", busy, 1'b0);
    check("midrst_done", done, 1'b0);
    check("midrst_err", err, 1'b0);
    check("midrst_arvalid", arvalid_s_inf, 1'b0);
    check("midrst_araddr", araddr_s_inf, 32'h0);
    check("midrst_arlen", arlen_s_inf, 8'h0);
    check("midrst_rready", rready_s_inf, 1'b0);
    check("midrst_dout_valid", dout_valid, 1'b0);
    check("midrst_dout_data", dout_data, 128'h0);
    check("midrst_dout_idx", dout_idx, 8'h0);
    check("midrst_dout_last", dout_last, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Clean fetch after reset
    start_fetch(11);
    finish_fetch(11, 1'b0, cyc);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/isp_dram_reader.md
Name: isp_dram_reader

Overview:
AXI4 read-burst master that fetches one raw picture from DRAM and streams it, beat by beat, into the ISP processing core. It sits directly upstream of the ISP core and feeds it 128-bit pixel beats over a valid/ready stream. A small elastic FIFO decouples DRAM read-data timing from core backpressure. Each picture is 32x32x3 bytes = 3072 bytes = 192 beats, fetched in a single INCR burst.

Parameters:
BASE_ADDR, 32'h0001_0000, DRAM address of picture 0
PIC_BYTES, 3072, byte stride between consecutive pictures
BEATS, 192, beats per picture (arlen = BEATS-1)
FIFO_DEPTH, 4, read-data buffer entries (power of 2)

Ports:
clk  in  1  clock
rst_n  in  1  async active-low reset
start  in  1  one-cycle request to fetch a picture
pic_no  in  4  picture index, sampled with start
busy  out  1  high from accepted start until done
done  out  1  one-cycle pulse after last beat leaves the FIFO
err  out  1  sticky error for current fetch; cleared on next accepted start
arid_s_inf  out  4  constant 0
araddr_s_inf  out  32  burst start address
arlen_s_inf  out  8  BEATS-1 (191)
arsize_s_inf  out  3  constant 3'b100
arburst_s_inf  out  2  constant 2'b01
arvalid_s_inf  out  1  address valid
arready_s_inf  in  1  address ready
rid_s_inf  in  4  read id
rdata_s_inf  in  128  read data
rresp_s_inf  in  2  read response
rlast_s_inf  in  1  last beat
rvalid_s_inf  in  1  read data valid
rready_s_inf  out  1  read data ready
dout_valid  out  1  beat available to core
dout_ready  in  1  core accepts beat
dout_data  out  128  pixel beat, byte 0 in bits [7:0]
dout_idx  out  8  beat index 0..BEATS-1
dout_last  out  1  high with beat BEATS-1

Behaviour:
- Clock clk; reset rst_n, asynchronous, active-low. All outputs registered except rready_s_inf, dout_* (FIFO head).
- Reset values: busy 0, done 0, err 0, arvalid 0, araddr 0, arlen 0, rready 0, dout_valid 0, dout_data 0, dout_idx 0, dout_last 0; FIFO empty; state IDLE. arid/arsize/arburst constant.
- States: IDLE -> AR -> RD -> DRAIN -> IDLE.
- IDLE: start=1 latches pic_no, clears err, sets busy; next state AR. araddr = BASE_ADDR + pic_no*PIC_BYTES (32-bit, no overflow for 0..15), arlen = BEATS-1, registered so arvalid rises the cycle after start.
- AR: arvalid held 1, araddr/arlen stable until arready=1 sampled with arvalid; then arvalid 0 next cycle, state RD, beat counter = 0.
- RD: rready_s_inf = (fifo_count < FIFO_DEPTH), from registered count only; no combinational path from dout_ready. Beat accepted when rvalid & rready: pushed with idx = counter, last = (counter==BEATS-1); counter increments.
- Errors (err set, sticky): rresp != 0; rid != 0; rlast=1 on beat < BEATS-1; rlast=0 on beat BEATS-1. Data still forwarded; beat count always governs termination.
- After beat BEATS-1 accepted: state DRAIN, rready 0.
- DRAIN: wait FIFO empty; then done=1 for one cycle, busy 0, state IDLE.
- FIFO: push and pop in the same cycle allowed at any occupancy, including full (count unchanged). Pop when dout_valid & dout_ready. dout_valid = !empty.
- start while busy: ignored, pic_no not sampled.
- Reset mid-burst: FSM and FIFO cleared immediately; outstanding DRAM beats are not tracked (system reset also resets DRAM model).
- Throughput: 1 beat/cycle when core never stalls.

Decomposition:
- Shared package isp_pkg: AXI constants (AXI_SIZE_16B=3'b100, AXI_BURST_INCR=2'b01, AXI_RESP_OKAY), PIC_BYTES, BEATS, BASE_ADDR, state enum.
- One sub-module: isp_beat_fifo (synchronous FIFO, 137-bit entries: data+idx+last, count output).

Test Plan:
- start, pic_no=0, arready same cycle, core always ready -> araddr 0x0001_0000, arlen 191, 192 beats dout_idx 0..191, dout_last only on 191, done ~195 cycles later, err 0.
- pic_no=15, arready delayed 7 cycles -> arvalid held 7+ cycles with araddr 0x0001_B400 stable; transfer completes.
- dout_ready low 10 cycles mid-burst -> rready drops after 4 buffered beats, no data lost or duplicated, order preserved.
- rresp=2'b10 on beat 5 -> err=1 through done; all 192 beats still delivered; next start clears err.
- rlast asserted on beat 100 -> err=1; fetch still terminates after beat 191.
- start pulsed while busy with pic_no=3 -> ignored, no second AR issued; rst_n low mid-RD -> all outputs at reset values immediately.
